// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter draining a downstream byte FIFO
// One pop per frame: start bit, 8 data bits LSB first, optional parity, stop bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST     = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] PRE_LAST = TW'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY_BIT, STOP
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_bit;
    logic          bit_end;

    assign bit_end = (timer == LAST);
    assign busy    = (state != IDLE);

    // tx is registered, so each transition loads the level of the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
            case (state)
                START, DATA, PARITY_BIT, STOP: timer <= bit_end ? '0 : timer + 1'b1;
                default:                       timer <= '0;
            endcase
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        state      <= FETCH;
                        fifo_rd_en <= 1'b1;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    shift   <= fifo_data;
                    par_bit <= (PARITY == 2) ? ~(^fifo_data) : ^fifo_data;
                    bit_idx <= '0;
                    tx      <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (PARITY != 0) begin
                                state <= PARITY_BIT;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            tx <= shift[1];
                        end
                    end
                end
                PARITY_BIT: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
                STOP: begin
                    // Raised one cycle early so the registered pulse lands in the last stop cycle
                    if (timer == PRE_LAST) tx_done <= 1'b1;
                    if (bit_end) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    initial forever #5 clk = ~clk;

    logic [7:0] m0 [16];
    logic [7:0] m1 [16];
    logic [7:0] m2 [16];
    int w0, r0, w1, r1, w2, r2;
    logic [7:0] d0, d1, d2;
    logic e0, e1, e2;
    logic rd0, rd1, rd2, tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
    int rd_cnt0, rd_cnt1, rd_cnt2;
    int n_checks, n_fail;

    assign e0 = (w0 == r0);
    assign e1 = (w1 == r1);
    assign e2 = (w2 == r2);

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0)) dut0 (
        .clk(clk), .rst(rst), .fifo_empty(e0), .fifo_data(d0),
        .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .tx_done(done0));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1)) dut1 (
        .clk(clk), .rst(rst), .fifo_empty(e1), .fifo_data(d1),
        .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .tx_done(done1));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut2 (
        .clk(clk), .rst(rst), .fifo_empty(e2), .fifo_data(d2),
        .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .tx_done(done2));

    // FIFO read ports with registered data_out
    always @(posedge clk) if (rd0 === 1'b1 && w0 != r0) begin d0 <= m0[r0[3:0]]; r0 <= r0 + 1; end
    always @(posedge clk) if (rd1 === 1'b1 && w1 != r1) begin d1 <= m1[r1[3:0]]; r1 <= r1 + 1; end
    always @(posedge clk) if (rd2 === 1'b1 && w2 != r2) begin d2 <= m2[r2[3:0]]; r2 <= r2 + 1; end

    always @(negedge clk) begin
        if (rd0 === 1'b1) rd_cnt0++;
        if (rd1 === 1'b1) rd_cnt1++;
        if (rd2 === 1'b1) rd_cnt2++;
    end

    task automatic push(input int k, input logic [7:0] b);
        case (k)
            0: begin m0[w0[3:0]] = b; w0++; end
            1: begin m1[w1[3:0]] = b; w1++; end
            default: begin m2[w2[3:0]] = b; w2++; end
        endcase
    endtask

    function automatic logic tx_of(input int k);
        return (k == 0) ? tx0 : (k == 1) ? tx1 : tx2;
    endfunction
    function automatic logic busy_of(input int k);
        return (k == 0) ? busy0 : (k == 1) ? busy1 : busy2;
    endfunction
    function automatic logic done_of(input int k);
        return (k == 0) ? done0 : (k == 1) ? done1 : done2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // frame[i] is the line level of bit slot i, slot 0 being the start bit
    task automatic check_frame(input int k, input string tag, input logic [10:0] frame, input int nbits);
        int wait_n = 0;
        int bad_tx = 0;
        int bad_busy = 0;
        int done_cnt = 0;
        int done_last = 0;
        while (tx_of(k) !== 1'b0 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, "_start"}, 32'(tx_of(k)), 32'd0);
        for (int i = 0; i < nbits * CPB; i++) begin
            if (i > 0) @(negedge clk);
            if (tx_of(k) !== frame[i / CPB]) bad_tx++;
            if (busy_of(k) !== 1'b1) bad_busy++;
            if (done_of(k) === 1'b1) begin
                done_cnt++;
                if (i == nbits * CPB - 1) done_last = 1;
            end
        end
        check({tag, "_tx_bad_cycles"}, bad_tx, 0);
        check({tag, "_busy_bad_cycles"}, bad_busy, 0);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_in_last"}, done_last, 1);
    endtask

    initial begin
        int bad;
        int n;
        rst = 1'b1;
        push(0, 8'hA5);
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {tx0, rd0, busy0, done0}, 4'b1000);
        end
        rst = 1'b0;
        @(negedge clk);
        check("release_fetch", {rd0, busy0, tx0}, 3'b111);
        @(negedge clk);
        check("release_load", {rd0, busy0, tx0}, 3'b011);
        @(negedge clk);
        check("start_latency", tx0, 1'b0);
        check_frame(0, "a5", {1'b1, 8'hA5, 1'b0}, 10);
        check("a5_rd_pulses", rd_cnt0, 1);

        push(1, 8'h03);
        check_frame(1, "even_03", {1'b1, 1'b0, 8'h03, 1'b0}, 11);
        push(1, 8'h07);
        check_frame(1, "even_07", {1'b1, 1'b1, 8'h07, 1'b0}, 11);
        push(2, 8'h03);
        check_frame(2, "odd_03", {1'b1, 1'b1, 8'h03, 1'b0}, 11);
        check("parity_rd_pulses", {rd_cnt1[15:0], rd_cnt2[15:0]}, {16'd2, 16'd1});

        push(0, 8'h55);
        push(0, 8'h0F);
        check_frame(0, "b2b_55", {1'b1, 8'h55, 1'b0}, 10);
        @(negedge clk);
        check("gap_idle", {tx0, busy0, rd0}, 3'b100);
        @(negedge clk);
        check("gap_fetch", {tx0, busy0, rd0}, 3'b111);
        @(negedge clk);
        check("gap_load", {tx0, busy0, rd0}, 3'b110);
        @(negedge clk);
        check("gap_start", tx0, 1'b0);
        check_frame(0, "b2b_0f", {1'b1, 8'h0F, 1'b0}, 10);
        check("b2b_rd_pulses", rd_cnt0, 3);

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({tx0, rd0, busy0, done0} !== 4'b1000) bad++;
        end
        check("empty_idle_bad_cycles", bad, 0);
        check("empty_rd_pulses", rd_cnt0, 3);

        push(0, 8'hFF);
        push(0, 8'h81);
        n = 0;
        while (tx0 !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ff_start", tx0, 1'b0);
        repeat (17) @(negedge clk);
        check("ff_data_bit3", {tx0, busy0}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        check("midframe_reset", {tx0, busy0, rd0, done0}, 4'b1000);
        rst = 1'b0;
        check_frame(0, "after_reset_81", {1'b1, 8'h81, 1'b0}, 10);
        check("final_rd_pulses", rd_cnt0, 5);
        @(negedge clk);
        check("final_idle", {tx0, busy0}, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Byte-stream serializer that drains the 8-bit, 4-entry FIFO directly downstream of it and transmits each byte as an asynchronous UART frame: 1 start bit, 8 data bits LSB first, an optional parity bit, and 1 stop bit. It pops one entry at a time through the FIFO's read port (`rd_en`, registered `data_out`, `empty`). It sends frames back to back while the FIFO is non-empty and idles with the line high otherwise.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per bit period (50 MHz / 115200). Legal range is 2 or more.
- `PARITY`, default 0: 0 = no parity bit, 1 = even parity, 2 = odd parity.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  8  FIFO `data_out`; valid in the cycle after `fifo_rd_en` was high.
- `fifo_rd_en`  out  1  one-cycle pop request to the FIFO; registered.
- `tx`  out  1  serial line; idle level is 1; registered.
- `busy`  out  1  high whenever the state is not IDLE.
- `tx_done`  out  1  one-cycle pulse in the last clock of the stop bit.

## Operation

- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If `fifo_empty`=0, go to FETCH. Otherwise stay in IDLE.
- FETCH: `fifo_rd_en`=1 for this one cycle only. Go to LOAD.
- LOAD: capture `fifo_data` into an 8-bit shift register and compute the parity bit from it. Clear the bit-timer and go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles. Then shift right and increment the bit index (3 bits). After bit 7, go to PARITY if `PARITY`≠0, else to STOP.
- PARITY: `tx` carries the parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
  - Even parity: XOR of the 8 data bits.
  - Odd parity: inverse of that XOR.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles. `tx_done`=1 in the final cycle. Then go to IDLE.
- Bit-timer width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
- Exactly one FIFO pop per frame. `fifo_rd_en` is never asserted unless `fifo_empty` was 0 in the preceding IDLE cycle.
- The block ignores `fifo_empty` outside IDLE. The FIFO may be filled during a frame without any effect on it.

## Timing

- Reset values, in the cycle after `rst` is sampled high:
  - state = IDLE, `tx`=1, `fifo_rd_en`=0, `busy`=0, `tx_done`=0.
  - Bit-timer, bit index and shift register are all 0.
- Reset mid-frame: the frame is abandoned and `tx` returns to 1 on the next edge. A byte already popped is lost.
- Latency: with `fifo_empty` low in IDLE cycle N:
  - `fifo_rd_en`=1 in cycle N+1.
  - The byte is captured at the end of cycle N+2.
  - The start bit begins in cycle N+3.
- Frame length is (10 + (`PARITY`≠0)) × `CLKS_PER_BIT` cycles, measured from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back frames: IDLE, FETCH and LOAD add exactly 3 cycles of `tx`=1 between one stop bit and the next start bit.
- `busy` is 1 from FETCH through STOP inclusive.

## Test plan

- **Reset behaviour.** Hold `rst`=1 for 3 cycles with `fifo_empty`=0.
  - During reset: `tx`=1, `fifo_rd_en`=0, `busy`=0.
  - After release: `fifo_rd_en` pulses 1 cycle later.
- **Single frame, `CLKS_PER_BIT`=4, `PARITY`=0, FIFO holding 0xA5.**
  - `tx` sequence, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1 (40 cycles).
  - `tx_done` pulses once, in cycle 40.
  - Exactly one `fifo_rd_en` pulse.
- **Parity, `CLKS_PER_BIT`=4.**
  - `PARITY`=1 with 0x03: parity bit is 0.
  - `PARITY`=2 with 0x03: parity bit is 1.
  - `PARITY`=1 with 0x07: parity bit is 1.
  - Each frame is 44 cycles.
- **Back-to-back, FIFO holding 0x55 then 0x0F.**
  - Two frames with exactly 3 idle-high cycles between the stop bit and the next start bit.
  - Two `fifo_rd_en` pulses; `busy` low only during the IDLE gap cycle.
  - `tx` stays 1 afterwards while `fifo_empty`=1.
- **Empty FIFO.** Hold `fifo_empty`=1 for 100 cycles: `fifo_rd_en`, `busy` and `tx_done` stay 0, and `tx` stays 1.
- **Reset mid-frame.** Assert `rst` during data bit 3 of 0xFF.
  - `tx`=1 on the next edge and the state is IDLE.
  - The next queued byte, 0x81, is then sent correctly as a full frame.
